// File: rtl/bus_pkg.sv
// Shared definitions for the clocked bus transceiver.
package bus_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_A2B  = 2'd1,
    ST_B2A  = 2'd2,
    ST_TURN = 2'd3
  } state_t;

endpackage

// File: rtl/bus_transceiver_sync_tri_driver.sv
// WIDTH-wide bufif1-style driver: drives out with in while en, else releases.
module tri_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output wire  [WIDTH-1:0] out
);

  // Release the bus (Z) whenever the enable is low.
  assign out = en ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_transceiver_sync.sv
// Clocked bidirectional transceiver between bus a and bus b with a
// programmable dead-time turnaround and optional registered data path.
module bus_transceiver_sync
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter bit          REG_OUT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             g,
  input  logic             dir,
  output logic             busy,
  output logic [1:0]       state
);

  localparam bit HAS_DEAD = (DEAD_CYCLES != 0);
  // Counter starts at DEAD_CYCLES-1 so TURN spans exactly DEAD_CYCLES cycles.
  localparam logic [CNT_W-1:0] TURN_LOAD =
    HAS_DEAD ? CNT_W'(DEAD_CYCLES - 1) : '0;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             en_a, en_b;
  logic [WIDTH-1:0] a_drv, b_drv;

  // State, dead-time counter and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_OFF;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      busy_q <= (st_d == ST_TURN);
    end
  end

  // Next-state and counter decode; g=1 overrides everything.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (g) begin
      st_d  = ST_OFF;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        ST_OFF: begin
          st_d = dir ? ST_A2B : ST_B2A;
        end
        ST_A2B: begin
          if (!dir) begin
            if (HAS_DEAD) begin
              st_d  = ST_TURN;
              cnt_d = TURN_LOAD;
            end else begin
              st_d = ST_B2A;
            end
          end
        end
        ST_B2A: begin
          if (dir) begin
            if (HAS_DEAD) begin
              st_d  = ST_TURN;
              cnt_d = TURN_LOAD;
            end else begin
              st_d = ST_A2B;
            end
          end
        end
        ST_TURN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            st_d = dir ? ST_A2B : ST_B2A;
          end
        end
        default: begin
          st_d  = ST_OFF;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Drive enables come only from the registered state, so at most one is high.
  assign en_b  = (st_q == ST_A2B);
  assign en_a  = (st_q == ST_B2A);
  assign busy  = busy_q;
  assign state = st_q;

  // Data path: register sampled on every edge that enters or stays in a
  // driving state, or a straight combinational pass-through.
  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] data_q;

    // Capture the source side whenever the next state drives; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (st_d == ST_A2B) begin
        data_q <= a;
      end else if (st_d == ST_B2A) begin
        data_q <= b;
      end
    end

    assign a_drv = data_q;
    assign b_drv = data_q;
  end else begin : g_comb
    assign a_drv = b;
    assign b_drv = a;
  end

  tri_driver #(.WIDTH(WIDTH)) u_drv_b (
    .in  (b_drv),
    .en  (en_b),
    .out (b)
  );

  tri_driver #(.WIDTH(WIDTH)) u_drv_a (
    .in  (a_drv),
    .en  (en_a),
    .out (a)
  );

endmodule

// File: tb/tb_bus_transceiver_sync.sv
// Bench for bus_transceiver_sync: three instances (dead=2 comb, dead=0 comb,
// dead=2 registered) on pulled-down buses so a released side reads 0.
module tb_bus_transceiver_sync;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         g_i   [3];
  logic         dir_i [3];
  logic [W-1:0] a_val [3];
  logic [W-1:0] b_val [3];
  logic         a_oe  [3];
  logic         b_oe  [3];

  tri0 [W-1:0] a0, a1, a2, b0, b1, b2;
  logic [1:0]  st0, st1, st2;
  logic        bz0, bz1, bz2;

  int checks = 0;
  int errors = 0;

  assign a0 = a_oe[0] ? a_val[0] : 'z;
  assign b0 = b_oe[0] ? b_val[0] : 'z;
  assign a1 = a_oe[1] ? a_val[1] : 'z;
  assign b1 = b_oe[1] ? b_val[1] : 'z;
  assign a2 = a_oe[2] ? a_val[2] : 'z;
  assign b2 = b_oe[2] ? b_val[2] : 'z;

  bus_transceiver_sync #(.WIDTH(W), .DEAD_CYCLES(2), .REG_OUT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .g(g_i[0]), .dir(dir_i[0]),
    .busy(bz0), .state(st0));

  bus_transceiver_sync #(.WIDTH(W), .DEAD_CYCLES(0), .REG_OUT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .g(g_i[1]), .dir(dir_i[1]),
    .busy(bz1), .state(st1));

  bus_transceiver_sync #(.WIDTH(W), .DEAD_CYCLES(2), .REG_OUT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .g(g_i[2]), .dir(dir_i[2]),
    .busy(bz2), .state(st2));

  function automatic logic [W-1:0] rd_a(input int k);
    case (k)
      0:       return a0;
      1:       return a1;
      default: return a2;
    endcase
  endfunction

  function automatic logic [W-1:0] rd_b(input int k);
    case (k)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  function automatic logic [1:0] rd_st(input int k);
    case (k)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic logic rd_busy(input int k);
    case (k)
      0:       return bz0;
      1:       return bz1;
      default: return bz2;
    endcase
  endfunction

  task automatic drv(input int k, input logic aoe, input logic [W-1:0] av,
                     input logic boe, input logic [W-1:0] bv);
    a_oe[k]  = aoe;
    a_val[k] = av;
    b_oe[k]  = boe;
    b_val[k] = bv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st0); end
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bz0); end
    checks++; if (b0 !== 8'h00) begin errors++; $display("FAIL reset_b_released got %h want 00", b0); end
    checks++; if (a0 !== 8'hA5) begin errors++; $display("FAIL reset_a_bench got %h want a5", a0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL first_edge_state got %0d want 1", st0); end
    checks++; if (b0 !== 8'hA5) begin errors++; $display("FAIL first_edge_b got %h want a5", b0); end
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL first_edge_busy got %b want 0", bz0); end
  endtask

  task automatic test_turnaround();
    drv(0, 1'b1, 8'h3C, 1'b0, 8'h00);
    #1;
    checks++; if (b0 !== 8'h3C) begin errors++; $display("FAIL a2b_pass got %h want 3c", b0); end
    dir_i[0] = 1'b0;
    step();
    drv(0, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (st0 !== 2'd3 || bz0 !== 1'b1) begin errors++; $display("FAIL turn1_state got st=%0d busy=%b want 3/1", st0, bz0); end
    checks++; if (a0 !== 8'h00 || b0 !== 8'h00) begin errors++; $display("FAIL turn1_released got a=%h b=%h want 00/00", a0, b0); end
    drv(0, 1'b0, 8'h00, 1'b1, 8'hC3);
    #1;
    checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL turn1_a_hold got %h want 00", a0); end
    step();
    #1;
    checks++; if (st0 !== 2'd3 || bz0 !== 1'b1 || a0 !== 8'h00) begin errors++; $display("FAIL turn2 got st=%0d busy=%b a=%h want 3/1/00", st0, bz0, a0); end
    step();
    #1;
    checks++; if (st0 !== 2'd2 || bz0 !== 1'b0 || a0 !== 8'hC3) begin errors++; $display("FAIL turn_exit got st=%0d busy=%b a=%h want 2/0/c3", st0, bz0, a0); end
  endtask

  task automatic test_abort();
    dir_i[0] = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'd3 || bz0 !== 1'b1) begin errors++; $display("FAIL abort_enter got st=%0d busy=%b want 3/1", st0, bz0); end
    g_i[0] = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'd0 || bz0 !== 1'b0) begin errors++; $display("FAIL abort_off got st=%0d busy=%b want 0/0", st0, bz0); end
    g_i[0] = 1'b0;
    dir_i[0] = 1'b1;
    drv(0, 1'b1, 8'h5A, 1'b0, 8'h00);
    step();
    #1;
    checks++; if (st0 !== 2'd1 || b0 !== 8'h5A) begin errors++; $display("FAIL off_to_a2b got st=%0d b=%h want 1/5a", st0, b0); end
    dir_i[0] = 1'b0;
    step();
    dir_i[0] = 1'b1;
    #1;
    checks++; if (st0 !== 2'd3 || b0 !== 8'h00) begin errors++; $display("FAIL flip_turn1 got st=%0d b=%h want 3/00", st0, b0); end
    step();
    #1;
    checks++; if (st0 !== 2'd3 || bz0 !== 1'b1 || b0 !== 8'h00) begin errors++; $display("FAIL flip_turn2 got st=%0d busy=%b b=%h want 3/1/00", st0, bz0, b0); end
    dir_i[0] = 1'b0;
    #2;
    dir_i[0] = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'd1 || bz0 !== 1'b0 || b0 !== 8'h5A) begin errors++; $display("FAIL flip_exit got st=%0d busy=%b b=%h want 1/0/5a", st0, bz0, b0); end
  endtask

  task automatic test_dead0();
    drv(1, 1'b1, 8'h77, 1'b0, 8'h00);
    g_i[1] = 1'b0;
    dir_i[1] = 1'b1;
    step();
    #1;
    checks++; if (st1 !== 2'd1 || bz1 !== 1'b0 || b1 !== 8'h77) begin errors++; $display("FAIL d0_a2b got st=%0d busy=%b b=%h want 1/0/77", st1, bz1, b1); end
    dir_i[1] = 1'b0;
    step();
    drv(1, 1'b0, 8'h00, 1'b1, 8'h88);
    #1;
    checks++; if (st1 !== 2'd2 || bz1 !== 1'b0 || a1 !== 8'h88) begin errors++; $display("FAIL d0_b2a got st=%0d busy=%b a=%h want 2/0/88", st1, bz1, a1); end
    dir_i[1] = 1'b1;
    step();
    drv(1, 1'b1, 8'h99, 1'b0, 8'h00);
    #1;
    checks++; if (st1 !== 2'd1 || bz1 !== 1'b0 || b1 !== 8'h99) begin errors++; $display("FAIL d0_back got st=%0d busy=%b b=%h want 1/0/99", st1, bz1, b1); end
  endtask

  task automatic test_reg_out();
    drv(2, 1'b1, 8'h01, 1'b0, 8'h00);
    g_i[2] = 1'b0;
    dir_i[2] = 1'b1;
    step();
    drv(2, 1'b1, 8'h02, 1'b0, 8'h00);
    #1;
    checks++; if (st2 !== 2'd1 || b2 !== 8'h01) begin errors++; $display("FAIL reg_entry got st=%0d b=%h want 1/01", st2, b2); end
    step();
    drv(2, 1'b1, 8'h03, 1'b0, 8'h00);
    #1;
    checks++; if (b2 !== 8'h02) begin errors++; $display("FAIL reg_lag2 got %h want 02", b2); end
    step();
    #1;
    checks++; if (b2 !== 8'h03) begin errors++; $display("FAIL reg_lag3 got %h want 03", b2); end
    g_i[2] = 1'b1;
    drv(2, 1'b1, 8'h55, 1'b0, 8'h00);
    step();
    #1;
    checks++; if (st2 !== 2'd0 || b2 !== 8'h00) begin errors++; $display("FAIL reg_off got st=%0d b=%h want 0/00", st2, b2); end
    g_i[2] = 1'b0;
    step();
    drv(2, 1'b1, 8'h66, 1'b0, 8'h00);
    #1;
    checks++; if (st2 !== 2'd1 || b2 !== 8'h55) begin errors++; $display("FAIL reg_reentry got st=%0d b=%h want 1/55", st2, b2); end
    step();
    #1;
    checks++; if (b2 !== 8'h66) begin errors++; $display("FAIL reg_follow got %h want 66", b2); end
  endtask

  // Random g/dir/data against a cycle-count model of the direction rules.
  task automatic test_random(input int k, input int dead);
    int       mode;   // 0 off, 1 a->b, 2 b->a, 3 turnaround
    int       left;   // turnaround cycles still to go
    int       run;
    bit       aborted;
    logic     cg, cd;
    logic [W-1:0] v;
    g_i[k] = 1'b1;
    drv(k, 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    mode = 0; left = 0; run = 0; aborted = 1'b0; cd = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      cg = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) cd = ~cd;
      g_i[k] = cg;
      dir_i[k] = cd;
      step();
      if (cg) begin
        if (mode == 3) aborted = 1'b1;
        mode = 0;
        left = 0;
      end else if (mode == 0) begin
        mode = cd ? 1 : 2;
      end else if (mode == 3) begin
        left = left - 1;
        if (left == 0) mode = cd ? 1 : 2;
      end else if ((cd ? 1 : 2) != mode) begin
        if (dead > 0) begin
          mode = 3;
          left = dead;
        end else begin
          mode = cd ? 1 : 2;
        end
      end
      v = 8'($urandom_range(1, 255));
      case (mode)
        1: drv(k, 1'b1, v, 1'b0, 8'h00);
        2: drv(k, 1'b0, 8'h00, 1'b1, v);
        default: begin
          if ($urandom_range(0, 1) == 1) drv(k, 1'b1, v, 1'b0, 8'h00);
          else drv(k, 1'b0, 8'h00, 1'b1, v);
        end
      endcase
      #1;
      checks++; if (rd_st(k) !== 2'(mode)) begin errors++; $display("FAIL rnd%0d_state cyc %0d got %0d want %0d", k, n, rd_st(k), mode); end
      checks++; if (rd_busy(k) !== (mode == 3)) begin errors++; $display("FAIL rnd%0d_busy cyc %0d got %b want %b", k, n, rd_busy(k), (mode == 3)); end
      if (mode == 1) begin
        checks++; if (rd_b(k) !== v) begin errors++; $display("FAIL rnd%0d_b cyc %0d got %h want %h", k, n, rd_b(k), v); end
      end else if (mode == 2) begin
        checks++; if (rd_a(k) !== v) begin errors++; $display("FAIL rnd%0d_a cyc %0d got %h want %h", k, n, rd_a(k), v); end
      end else if (a_oe[k]) begin
        checks++; if (rd_b(k) !== 8'h00) begin errors++; $display("FAIL rnd%0d_b_release cyc %0d got %h want 00", k, n, rd_b(k)); end
      end else begin
        checks++; if (rd_a(k) !== 8'h00) begin errors++; $display("FAIL rnd%0d_a_release cyc %0d got %h want 00", k, n, rd_a(k)); end
      end
      if (rd_busy(k)) begin
        run++;
      end else begin
        if (run > 0 && !aborted) begin
          checks++; if (run != dead) begin errors++; $display("FAIL rnd%0d_busy_len cyc %0d got %0d want %0d", k, n, run, dead); end
        end
        run = 0;
        aborted = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    g_i[0] = 1'b0;
    dir_i[0] = 1'b1;
    drv(0, 1'b1, 8'h4B, 1'b0, 8'h00);
    repeat (4) step();
    #1;
    checks++; if (st0 !== 2'd1 || b0 !== 8'h4B) begin errors++; $display("FAIL pre_async got st=%0d b=%h want 1/4b", st0, b0); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (st0 !== 2'd0 || bz0 !== 1'b0 || b0 !== 8'h00) begin errors++; $display("FAIL async_reset got st=%0d busy=%b b=%h want 0/0/00", st0, bz0, b0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'd1 || b0 !== 8'h4B) begin errors++; $display("FAIL post_async got st=%0d b=%h want 1/4b", st0, b0); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      g_i[k] = 1'b1;
      dir_i[k] = 1'b1;
      drv(k, 1'b0, 8'h00, 1'b0, 8'h00);
    end
    g_i[0] = 1'b0;
    drv(0, 1'b1, 8'hA5, 1'b0, 8'h00);
    test_reset();
    test_turnaround();
    test_abort();
    test_dead0();
    test_reg_out();
    test_random(0, 2);
    test_random(1, 0);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
